ppc_regs: RTL and testbench



---
 rtl/ppc_regs_pkg.sv | 15 +
 rtl/ppc_regs_rport.sv | 51 +++++
 rtl/ppc_regs.sv | 77 +++++++
 tb/tb_ppc_regs.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppc_regs_pkg.sv
// ppc_regs_pkg: shared constants and types for the GPR file.
`default_nettype none

package ppc_regs_pkg;

    localparam int GPR_COUNT  = 32;
    localparam int GPR_ADDR_W = 5;
    localparam int GPR_DATA_W = 64;

    typedef logic [GPR_ADDR_W-1:0] gpr_addr_t;
    typedef logic [0:GPR_DATA_W-1] gpr_data_t;

endpackage

`default_nettype wire

// File: rtl/ppc_regs_rport.sv
// ppc_regs_rport: one registered read port with enable-hold.
// PPC_REGS_BYPASS_EN adds same-edge write-to-read bypass.
`default_nettype none

module ppc_regs_rport
    import ppc_regs_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [0:DATA_W-1] mem_i [2**ADDR_W],
`ifdef PPC_REGS_BYPASS_EN
    input  logic              wr_en0_i,
    input  logic [ADDR_W-1:0] wr_addr0_i,
    input  logic [0:DATA_W-1] wr_data0_i,
    input  logic              wr_en1_i,
    input  logic [ADDR_W-1:0] wr_addr1_i,
    input  logic [0:DATA_W-1] wr_data1_i,
`endif
    output logic [0:DATA_W-1] rd_data_o
);

    logic [0:DATA_W-1] rd_data_q;
    logic [0:DATA_W-1] rd_data_d;

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_i[rd_addr_i];
`ifdef PPC_REGS_BYPASS_EN
            // Port 1 checked last so it wins when both writes hit this address.
            if (wr_en0_i && (wr_addr0_i == rd_addr_i)) rd_data_d = wr_data0_i;
            if (wr_en1_i && (wr_addr1_i == rd_addr_i)) rd_data_d = wr_data1_i;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/ppc_regs.sv
// ppc_regs: 32 x 64-bit GPR file, two registered read ports, two write ports.
// Build option PPC_REGS_BYPASS_EN: same-edge write data forwarded to reads.
`default_nettype none

module ppc_regs
    import ppc_regs_pkg::*;
#(
    parameter int DATA_W = GPR_DATA_W,
    parameter int ADDR_W = GPR_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              readEn0,
    input  logic [ADDR_W-1:0] readAddr0,
    output logic [0:DATA_W-1] readData0,
    input  logic              readEn1,
    input  logic [ADDR_W-1:0] readAddr1,
    output logic [0:DATA_W-1] readData1,
    input  logic              writeEn0,
    input  logic [ADDR_W-1:0] writeAddr0,
    input  logic [0:DATA_W-1] writeData0,
    input  logic              writeEn1,
    input  logic [ADDR_W-1:0] writeAddr1,
    input  logic [0:DATA_W-1] writeData1
);

    localparam int DEPTH = 2**ADDR_W;

    logic [0:DATA_W-1] mem_q [DEPTH];

    // Port 1 written after port 0 so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (writeEn0) mem_q[writeAddr0] <= writeData0;
            if (writeEn1) mem_q[writeAddr1] <= writeData1;
        end
    end

    ppc_regs_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport0 (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (readEn0),
        .rd_addr_i  (readAddr0),
        .mem_i      (mem_q),
`ifdef PPC_REGS_BYPASS_EN
        .wr_en0_i   (writeEn0),
        .wr_addr0_i (writeAddr0),
        .wr_data0_i (writeData0),
        .wr_en1_i   (writeEn1),
        .wr_addr1_i (writeAddr1),
        .wr_data1_i (writeData1),
`endif
        .rd_data_o  (readData0)
    );

    ppc_regs_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rport1 (
        .clk        (clk),
        .rst        (rst),
        .rd_en_i    (readEn1),
        .rd_addr_i  (readAddr1),
        .mem_i      (mem_q),
`ifdef PPC_REGS_BYPASS_EN
        .wr_en0_i   (writeEn0),
        .wr_addr0_i (writeAddr0),
        .wr_data0_i (writeData0),
        .wr_en1_i   (writeEn1),
        .wr_addr1_i (writeAddr1),
        .wr_data1_i (writeData1),
`endif
        .rd_data_o  (readData1)
    );

endmodule

`default_nettype wire

// File: tb/tb_ppc_regs.sv
// tb_ppc_regs: scoreboard bench for the GPR file; reference model predicts read data.
`default_nettype none

module tb_ppc_regs;
    import ppc_regs_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      readEn0, readEn1, writeEn0, writeEn1;
    gpr_addr_t readAddr0, readAddr1, writeAddr0, writeAddr1;
    gpr_data_t readData0, readData1, writeData0, writeData1;

    ppc_regs dut (
        .clk        (clk),
        .rst        (rst),
        .readEn0    (readEn0),
        .readAddr0  (readAddr0),
        .readData0  (readData0),
        .readEn1    (readEn1),
        .readAddr1  (readAddr1),
        .readData1  (readData1),
        .writeEn0   (writeEn0),
        .writeAddr0 (writeAddr0),
        .writeData0 (writeData0),
        .writeEn1   (writeEn1),
        .writeAddr1 (writeAddr1),
        .writeData1 (writeData1)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    gpr_data_t mdl [GPR_COUNT];
    gpr_data_t out0_m, out1_m;
    gpr_data_t sb0 [$];
    gpr_data_t sb1 [$];
    gpr_data_t e0, e1;

    function automatic gpr_data_t predict(input gpr_data_t cur, input logic en, input gpr_addr_t a);
        gpr_data_t r;
        r = cur;
        if (en) begin
            r = mdl[a];
`ifdef PPC_REGS_BYPASS_EN
            if (writeEn0 && writeAddr0 == a) r = writeData0;
            if (writeEn1 && writeAddr1 == a) r = writeData1;
`endif
        end
        if (rst) r = '0;
        return r;
    endfunction

    // Advance one edge with the currently driven inputs; push predictions for selected ports.
    task automatic tick(input bit c0, input bit c1);
        gpr_data_t n0, n1;
        n0 = predict(out0_m, readEn0, readAddr0);
        n1 = predict(out1_m, readEn1, readAddr1);
        if (rst) begin
            for (int i = 0; i < GPR_COUNT; i++) mdl[i] = '0;
        end else begin
            if (writeEn0) mdl[writeAddr0] = writeData0;
            if (writeEn1) mdl[writeAddr1] = writeData1;
        end
        @(posedge clk);
        #1;
        out0_m = n0;
        out1_m = n1;
        if (c0) sb0.push_back(n0);
        if (c1) sb1.push_back(n1);
    endtask

    task automatic idle();
        rst = 0; readEn0 = 0; readEn1 = 0; writeEn0 = 0; writeEn1 = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1;
        tick(1, 1);
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL reset_out0 got %h exp %h", readData0, e0); end
        e1 = sb1.pop_front(); checks++;
        if (readData1 !== e1) begin errors++; $display("FAIL reset_out1 got %h exp %h", readData1, e1); end
        idle(); writeEn0 = 1; writeAddr0 = 5'd7; writeData0 = 64'd5;
        tick(0, 0);
        // Reset cycle with a concurrent write to r8 and read of r7: both must be overridden.
        idle(); rst = 1; writeEn1 = 1; writeAddr1 = 5'd8; writeData1 = 64'hFF;
        readEn0 = 1; readAddr0 = 5'd7;
        tick(1, 0);
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL reset_override got %h exp %h", readData0, e0); end
        idle(); readEn0 = 1; readAddr0 = 5'd7; readEn1 = 1; readAddr1 = 5'd8;
        tick(1, 1);
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL reset_r7 got %h exp %h", readData0, e0); end
        e1 = sb1.pop_front(); checks++;
        if (readData1 !== e1) begin errors++; $display("FAIL reset_r8_write_dropped got %h exp %h", readData1, e1); end
    endtask

    task automatic test_basic();
        idle(); writeEn0 = 1; writeAddr0 = 5'd3; writeData0 = 64'h0000_0000_DEAD_BEEF;
        writeEn1 = 1; writeAddr1 = 5'd0; writeData1 = 64'h8000_0000_0000_0001;
        tick(0, 0);
        idle(); readEn1 = 1; readAddr1 = 5'd3; readEn0 = 1; readAddr0 = 5'd0;
        tick(1, 1);
        e1 = sb1.pop_front(); checks++;
        if (readData1 !== e1) begin errors++; $display("FAIL basic_r3 got %h exp %h", readData1, e1); end
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL basic_r0_not_zero got %h exp %h", readData0, e0); end
    endtask

    task automatic test_same_edge();
        idle(); writeEn0 = 1; writeAddr0 = 5'd4; writeData0 = 64'd1;
        tick(0, 0);
        idle(); writeEn0 = 1; writeAddr0 = 5'd4; writeData0 = 64'd2; readEn0 = 1; readAddr0 = 5'd4;
        tick(1, 0);
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL same_edge_first got %h exp %h", readData0, e0); end
        idle(); readEn0 = 1; readAddr0 = 5'd4;
        tick(1, 0);
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL same_edge_second got %h exp %h", readData0, e0); end
    endtask

    task automatic test_dual_conflict();
        idle(); writeEn0 = 1; writeAddr0 = 5'd9; writeData0 = 64'h11;
        writeEn1 = 1; writeAddr1 = 5'd9; writeData1 = 64'h22;
        readEn1 = 1; readAddr1 = 5'd9;
        tick(0, 1);
        e1 = sb1.pop_front(); checks++;
        if (readData1 !== e1) begin errors++; $display("FAIL conflict_same_edge got %h exp %h", readData1, e1); end
        idle(); readEn0 = 1; readAddr0 = 5'd9; readEn1 = 1; readAddr1 = 5'd9;
        tick(1, 1);
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL conflict_r9_p0 got %h exp %h", readData0, e0); end
        e1 = sb1.pop_front(); checks++;
        if (readData1 !== e1) begin errors++; $display("FAIL conflict_r9_p1 got %h exp %h", readData1, e1); end
    endtask

    task automatic test_dual_write();
        idle(); writeEn0 = 1; writeAddr0 = 5'd5; writeData0 = 64'hAAAA;
        writeEn1 = 1; writeAddr1 = 5'd6; writeData1 = 64'h5555;
        tick(0, 0);
        idle(); readEn0 = 1; readAddr0 = 5'd5; readEn1 = 1; readAddr1 = 5'd6;
        tick(1, 1);
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL dual_r5 got %h exp %h", readData0, e0); end
        e1 = sb1.pop_front(); checks++;
        if (readData1 !== e1) begin errors++; $display("FAIL dual_r6 got %h exp %h", readData1, e1); end
    endtask

    task automatic test_hold();
        idle(); writeEn0 = 1; writeAddr0 = 5'd3; writeData0 = 64'h1234;
        tick(0, 0);
        idle(); readEn0 = 1; readAddr0 = 5'd3; readEn1 = 1; readAddr1 = 5'd3;
        tick(1, 1);
        e0 = sb0.pop_front(); checks++;
        if (readData0 !== e0) begin errors++; $display("FAIL hold_load got %h exp %h", readData0, e0); end
        e1 = sb1.pop_front(); checks++;
        if (readData1 !== e1) begin errors++; $display("FAIL hold_load_p1 got %h exp %h", readData1, e1); end
        idle(); readAddr0 = 5'd9; readAddr1 = 5'd9;
        writeEn0 = 1; writeAddr0 = 5'd3; writeData0 = 64'hBAD;
        for (int k = 0; k < 2; k++) begin
            tick(1, 1);
            e0 = sb0.pop_front(); checks++;
            if (readData0 !== e0) begin errors++; $display("FAIL hold_p0 cyc%0d got %h exp %h", k, readData0, e0); end
            e1 = sb1.pop_front(); checks++;
            if (readData1 !== e1) begin errors++; $display("FAIL hold_p1 cyc%0d got %h exp %h", k, readData1, e1); end
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 300; k++) begin
            rst        = ($urandom_range(0, 49) == 0);
            readEn0    = $urandom_range(0, 3) != 0;
            readEn1    = $urandom_range(0, 3) != 0;
            writeEn0   = $urandom_range(0, 1) != 0;
            writeEn1   = $urandom_range(0, 1) != 0;
            readAddr0  = gpr_addr_t'($urandom_range(0, 7));
            readAddr1  = gpr_addr_t'($urandom_range(0, 7));
            writeAddr0 = gpr_addr_t'($urandom_range(0, 7));
            writeAddr1 = gpr_addr_t'($urandom_range(0, 7));
            writeData0 = {$urandom, $urandom};
            writeData1 = {$urandom, $urandom};
            tick(1, 1);
            e0 = sb0.pop_front(); checks++;
            if (readData0 !== e0) begin errors++; $display("FAIL b2b_p0 cyc%0d got %h exp %h", k, readData0, e0); end
            e1 = sb1.pop_front(); checks++;
            if (readData1 !== e1) begin errors++; $display("FAIL b2b_p1 cyc%0d got %h exp %h", k, readData1, e1); end
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < GPR_COUNT; i++) mdl[i] = '0;
        out0_m = '0; out1_m = '0;
        readAddr0 = '0; readAddr1 = '0; writeAddr0 = '0; writeAddr1 = '0;
        writeData0 = '0; writeData1 = '0;
        idle();
        #1;
        test_reset();
        test_basic();
        test_same_edge();
        test_dual_conflict();
        test_dual_write();
        test_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
